// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath and control widths, the zero-register
// index, the register-index type, and the ID/EX pipeline register layout.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;
  localparam int ZR     = 31;

  typedef logic [4:0] reg_idx_t;

  // ID/EX pipeline register contents. An all-zero value is a bubble.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] store_data;
    reg_idx_t          rd;
    logic              reg_write;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// fwd_mux: priority bypass for one source operand.
//   src            source register index being read in ID
//   ex_hit, ex_rd, ex_data      EX-stage writer (ex_hit = valid & reg_write)
//   mem_we, mem_rd, mem_data    MEM-stage writer
//   wb_we, wb_rd, wb_data       WB writer (same cycle as the regfile write)
//   rf_data        regfile read data for src
//   fwd            resolved operand value
// Priority: zero register, then EX, MEM, WB, regfile.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ZR     = cpu_pkg::ZR
) (
  input  logic [4:0]        src,
  input  logic              ex_hit,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_we,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] fwd
);

  localparam int          ZR_INT = ZR;
  localparam logic [4:0]  ZR_IDX = ZR_INT[4:0];

  // Once src is known not to be the zero register, any destination equal to
  // src is also not the zero register, so a ZR destination can never match.
  always_comb begin
    fwd = rf_data;
    if (src == ZR_IDX)
      fwd = '0;
    else if (ex_hit && (ex_rd == src))
      fwd = ex_data;
    else if (mem_we && (mem_rd == src))
      fwd = mem_data;
    else if (wb_we && (wb_rd == src))
      fwd = wb_data;
  end

endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: decode/operand stage downstream of the 32x64 regfile.
//   Drives regfile read addresses (rf_rr1/rf_rr2), resolves both source
//   operands through EX/MEM/WB bypasses, detects load-use hazards (stall),
//   and registers the result into the ID/EX register (ex_* outputs).
//   flush / id_valid=0 / stall load a bubble; only stall bubbles are
//   counted in bubble_cnt (saturating).
// The ID/EX register layout comes from cpu_pkg, so DATA_W and CTRL_W must
// match the package values.
module id_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int ZR     = cpu_pkg::ZR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rn,
  input  logic [4:0]        id_rm,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rn,
  input  logic              id_uses_rm,
  input  logic              id_use_imm,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  output logic [4:0]        rf_rr1,
  output logic [4:0]        rf_rr2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [4:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic [4:0]        wb_rd,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       bubble_cnt
);

  localparam int         ZR_INT = ZR;
  localparam logic [4:0] ZR_IDX = ZR_INT[4:0];

  idex_t             idex_p0;
  idex_t             idex_p1;
  logic [DATA_W-1:0] fwd_rn;
  logic [DATA_W-1:0] fwd_rm;
  logic              ex_hit;
  logic              load_use;

  assign rf_rr1 = id_rn;
  assign rf_rr2 = id_rm;

  assign ex_hit = idex_p1.valid & idex_p1.reg_write;

  // ---- ID: operand resolution and hazard detection ----
  fwd_mux #(.DATA_W(DATA_W), .ZR(ZR)) u_fwd_rn (
    .src      (id_rn),
    .ex_hit   (ex_hit),
    .ex_rd    (idex_p1.rd),
    .ex_data  (ex_result),
    .mem_we   (mem_reg_write),
    .mem_rd   (mem_rd),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_reg_write),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .rf_data  (rf_rd1),
    .fwd      (fwd_rn)
  );

  fwd_mux #(.DATA_W(DATA_W), .ZR(ZR)) u_fwd_rm (
    .src      (id_rm),
    .ex_hit   (ex_hit),
    .ex_rd    (idex_p1.rd),
    .ex_data  (ex_result),
    .mem_we   (mem_reg_write),
    .mem_rd   (mem_rd),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_reg_write),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .rf_data  (rf_rd2),
    .fwd      (fwd_rm)
  );

  // Load data is not available until MEM, so a consumer directly behind a
  // load must wait one cycle and then picks it up from the MEM bypass.
  assign load_use = id_valid & idex_p1.valid & idex_p1.is_load &
                    (idex_p1.rd != ZR_IDX) &
                    ((id_uses_rn & (idex_p1.rd == id_rn)) |
                     (id_uses_rm & (idex_p1.rd == id_rm)));

  // A flushed instruction is discarded, so there is nothing to hold for.
  assign stall = load_use & ~flush;

  always_comb begin
    idex_p0            = '0;
    idex_p0.valid      = 1'b1;
    idex_p0.op_a       = fwd_rn;
    idex_p0.op_b       = id_use_imm ? id_imm : fwd_rm;
    idex_p0.store_data = fwd_rm;
    idex_p0.rd         = id_rd;
    idex_p0.reg_write  = id_reg_write;
    idex_p0.is_load    = id_is_load;
    idex_p0.ctrl       = id_ctrl;
  end

  // ---- ID/EX register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_p1    <= '0;
      bubble_cnt <= '0;
    end else begin
      if (flush || !id_valid || stall)
        idex_p1 <= '0;
      else
        idex_p1 <= idex_p0;
      if (stall && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  // A bubble is all-zero, so reg_write and is_load are inherently gated.
  assign ex_valid      = idex_p1.valid;
  assign ex_op_a       = idex_p1.op_a;
  assign ex_op_b       = idex_p1.op_b;
  assign ex_store_data = idex_p1.store_data;
  assign ex_rd         = idex_p1.rd;
  assign ex_reg_write  = idex_p1.reg_write;
  assign ex_is_load    = idex_p1.is_load;
  assign ex_ctrl       = idex_p1.ctrl;

endmodule

// File: tb/tb_id_operand_stage.sv
// Testbench for id_operand_stage: directed vectors, expected ID/EX contents
// pushed into a scoreboard queue and checked by an independent monitor.
module tb_id_operand_stage;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [4:0]        id_rn, id_rm, id_rd;
  logic              id_uses_rn, id_uses_rm, id_use_imm;
  logic [DATA_W-1:0] id_imm;
  logic              id_reg_write, id_is_load;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic [4:0]        rf_rr1, rf_rr2;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [DATA_W-1:0] ex_result;
  logic [4:0]        mem_rd;
  logic              mem_reg_write;
  logic [DATA_W-1:0] mem_fwd_data;
  logic [4:0]        wb_rd;
  logic              wb_reg_write;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_op_a, ex_op_b, ex_store_data;
  logic [4:0]        ex_rd;
  logic              ex_reg_write, ex_is_load;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       bubble_cnt;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rd(id_rd), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .id_use_imm(id_use_imm), .id_imm(id_imm), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl), .flush(flush),
    .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_result(ex_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_fwd_data(mem_fwd_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid), .ex_op_a(ex_op_a),
    .ex_op_b(ex_op_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] sd;
    logic [4:0]        rd;
    logic              rw;
    logic              ld;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       bc;
  } obs_t;

  obs_t  q_exp[$];
  string q_name[$];
  int    tests = 0;
  int    fails = 0;

  function automatic obs_t mk(logic v, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b,
                              logic [DATA_W-1:0] sd, logic [4:0] rd, logic rw,
                              logic ld, logic [CTRL_W-1:0] ctrl, logic [31:0] bc);
    obs_t o;
    o.valid = v; o.a = a; o.b = b; o.sd = sd; o.rd = rd;
    o.rw = rw; o.ld = ld; o.ctrl = ctrl; o.bc = bc;
    return o;
  endfunction

  function automatic obs_t bub(logic [31:0] bc);
    return mk(1'b0, '0, '0, '0, 5'd0, 1'b0, 1'b0, '0, bc);
  endfunction

  // Monitor: checks the ID/EX register just after every active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        obs_t  e, act;
        string n;
        e = q_exp.pop_front();
        n = q_name.pop_front();
        act = mk(ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_rd,
                 ex_reg_write, ex_is_load, ex_ctrl, bubble_cnt);
        tests++;
        if (act !== e) begin
          fails++;
          $display("FAIL %s: got v=%0b a=%h b=%h sd=%h rd=%0d rw=%0b ld=%0b ctrl=%h bc=%0d, expected v=%0b a=%h b=%h sd=%h rd=%0d rw=%0b ld=%0b ctrl=%h bc=%0d",
                   n, act.valid, act.a, act.b, act.sd, act.rd, act.rw, act.ld, act.ctrl, act.bc,
                   e.valid, e.a, e.b, e.sd, e.rd, e.rw, e.ld, e.ctrl, e.bc);
        end
      end
    end
  end

  // Called after inputs are set at the falling edge: checks the
  // combinational stall (optionally) and queues the expected ID/EX value.
  task automatic cyc(input string name, input logic chk_stall,
                     input logic exp_stall, input obs_t e);
    #1;
    if (chk_stall) begin
      tests++;
      if (stall !== exp_stall) begin
        fails++;
        $display("FAIL %s_stall: got %0b, expected %0b", name, stall, exp_stall);
      end
    end
    q_exp.push_back(e);
    q_name.push_back(name);
  endtask

  task automatic set_defaults();
    rst = 1'b0; id_valid = 1'b0; id_rn = 5'd0; id_rm = 5'd0; id_rd = 5'd0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0; id_use_imm = 1'b0; id_imm = '0;
    id_reg_write = 1'b0; id_is_load = 1'b0; id_ctrl = '0; flush = 1'b0;
    rf_rd1 = '0; rf_rd2 = '0; ex_result = '0; mem_rd = 5'd0;
    mem_reg_write = 1'b0; mem_fwd_data = '0; wb_rd = 5'd0;
    wb_reg_write = 1'b0; wb_data = '0;
  endtask

  // Common ALU-style instruction: reads rn and rm, writes rd.
  task automatic alu(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd);
    id_valid = 1'b1; id_rn = rn; id_rm = rm; id_rd = rd;
    id_uses_rn = 1'b1; id_uses_rm = 1'b1; id_use_imm = 1'b0;
    id_reg_write = 1'b1; id_is_load = 1'b0; id_ctrl = 16'h1234;
  endtask

  initial begin
    set_defaults();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    @(negedge clk);
    cyc("reset", 1'b1, 1'b0, bub(0));

    // Plain read of X5, no hazards
    @(negedge clk);
    set_defaults();
    alu(5'd5, 5'd6, 5'd1);
    rf_rd1 = 64'h11; rf_rd2 = 64'h22;
    cyc("plain_read", 1'b1, 1'b0, mk(1, 64'h11, 64'h22, 64'h22, 5'd1, 1, 0, 16'h1234, 0));

    // Same-cycle WB bypass, with an immediate operand B
    @(negedge clk);
    alu(5'd7, 5'd6, 5'd3);
    rf_rd1 = 64'h0; id_use_imm = 1'b1; id_imm = 64'h40;
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 64'hABC;
    cyc("wb_bypass", 1'b1, 1'b0, mk(1, 64'hABC, 64'h40, 64'h22, 5'd3, 1, 0, 16'h1234, 0));

    // EX, MEM, WB all target X3 -> EX wins
    @(negedge clk);
    alu(5'd3, 5'd6, 5'd4);
    ex_result = 64'd1;
    mem_reg_write = 1'b1; mem_rd = 5'd3; mem_fwd_data = 64'd2;
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 64'd3;
    cyc("prio_ex", 1'b1, 1'b0, mk(1, 64'd1, 64'h22, 64'h22, 5'd4, 1, 0, 16'h1234, 0));

    // EX now targets X4 -> MEM wins
    @(negedge clk);
    alu(5'd3, 5'd6, 5'd4);
    cyc("prio_mem", 1'b1, 1'b0, mk(1, 64'd2, 64'h22, 64'h22, 5'd4, 1, 0, 16'h1234, 0));

    // MEM write dropped -> WB wins
    @(negedge clk);
    alu(5'd3, 5'd6, 5'd4);
    mem_reg_write = 1'b0;
    cyc("prio_wb", 1'b1, 1'b0, mk(1, 64'd3, 64'h22, 64'h22, 5'd4, 1, 0, 16'h1234, 0));

    // Load to X9 enters EX
    @(negedge clk);
    set_defaults();
    alu(5'd5, 5'd6, 5'd9);
    id_is_load = 1'b1; id_use_imm = 1'b1; id_imm = 64'd8;
    rf_rd1 = 64'h11; rf_rd2 = 64'h22;
    cyc("load_issue", 1'b1, 1'b0, mk(1, 64'h11, 64'd8, 64'h22, 5'd9, 1, 1, 16'h1234, 0));

    // Load-use on rm=X9 -> stall, bubble, count 1
    @(negedge clk);
    set_defaults();
    alu(5'd5, 5'd9, 5'd31);
    rf_rd1 = 64'h11; rf_rd2 = 64'h0;
    cyc("load_use_stall", 1'b1, 1'b1, bub(1));

    // Held instruction now picks the load data up from MEM
    @(negedge clk);
    mem_reg_write = 1'b1; mem_rd = 5'd9; mem_fwd_data = 64'h55;
    cyc("load_use_mem", 1'b1, 1'b0, mk(1, 64'h11, 64'h55, 64'h55, 5'd31, 1, 0, 16'h1234, 1));

    // rn=X31 while EX writes X31 -> zero
    @(negedge clk);
    set_defaults();
    alu(5'd31, 5'd6, 5'd12);
    rf_rd1 = 64'h77; rf_rd2 = 64'h22; ex_result = 64'hFF;
    cyc("xzr_read", 1'b1, 1'b0, mk(1, 64'h0, 64'h22, 64'h22, 5'd12, 1, 0, 16'h1234, 1));

    // Another load to X9
    @(negedge clk);
    set_defaults();
    alu(5'd5, 5'd6, 5'd9);
    id_is_load = 1'b1; rf_rd1 = 64'h11; rf_rd2 = 64'h22;
    cyc("load_issue2", 1'b1, 1'b0, mk(1, 64'h11, 64'h22, 64'h22, 5'd9, 1, 1, 16'h1234, 1));

    // Flush together with a load-use hazard -> no stall, uncounted bubble
    @(negedge clk);
    set_defaults();
    alu(5'd5, 5'd9, 5'd10);
    flush = 1'b1;
    cyc("flush_vs_stall", 1'b1, 1'b0, bub(1));

    // Load again, then assert reset in the stall cycle
    @(negedge clk);
    set_defaults();
    alu(5'd5, 5'd6, 5'd9);
    id_is_load = 1'b1; rf_rd1 = 64'h11; rf_rd2 = 64'h22;
    cyc("load_issue3", 1'b1, 1'b0, mk(1, 64'h11, 64'h22, 64'h22, 5'd9, 1, 1, 16'h1234, 1));

    @(negedge clk);
    set_defaults();
    alu(5'd5, 5'd9, 5'd10);
    rf_rd1 = 64'h11; rf_rd2 = 64'h99;
    cyc("stall_before_rst", 1'b1, 1'b1, bub(1));
    rst = 1'b1;
    // Overwrite the queued expectation: rst beats the stall at this edge.
    void'(q_exp.pop_back());
    void'(q_name.pop_back());
    q_exp.push_back(bub(0));
    q_name.push_back("rst_mid_stall");

    // After reset: no residual stall, held instruction proceeds
    @(negedge clk);
    rst = 1'b0;
    cyc("after_rst", 1'b1, 1'b0, mk(1, 64'h11, 64'h99, 64'h99, 5'd10, 1, 0, 16'h1234, 0));

    // id_valid=0 -> uncounted bubble
    @(negedge clk);
    set_defaults();
    cyc("idle_bubble", 1'b1, 1'b0, bub(0));

    // Drain the scoreboard within a bounded number of cycles
    repeat (4) @(negedge clk);
    if (q_exp.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode/operand stage that sits directly downstream of the 32x64 register file. It drives regfile read addresses and consumes ReadData1/ReadData2.
- Resolves RAW hazards by bypassing results from the EX, MEM and WB stages, including a same-cycle WB-write bypass (the regfile has none). Detects load-use hazards and stalls.
- Registers the resolved operands into the ID/EX pipeline register that feeds EX.
- X31 is the zero register (XZR).

Parameters:
DATA_W, 64, operand/result width
CTRL_W, 16, opaque EX/MEM/WB control bundle width, passed through
ZR, 31, zero-register index; reads return 0, never matches a bypass

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  decoded instruction present in ID
id_rn  in  5  source A register index
id_rm  in  5  source B register index
id_rd  in  5  destination register index
id_uses_rn  in  1  instruction reads rn
id_uses_rm  in  1  instruction reads rm
id_use_imm  in  1  operand B = immediate
id_imm  in  DATA_W  sign-extended immediate
id_reg_write  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_ctrl  in  CTRL_W  downstream control bundle
flush  in  1  squash instruction in ID (taken branch)
rf_rr1  out  5  regfile ReadRegister1 (= id_rn)
rf_rr2  out  5  regfile ReadRegister2 (= id_rm)
rf_rd1  in  DATA_W  regfile ReadData1
rf_rd2  in  DATA_W  regfile ReadData2
ex_result  in  DATA_W  ALU result of the instruction now in EX (combinational)
mem_rd  in  5  MEM-stage destination
mem_reg_write  in  1  MEM-stage writes rd
mem_fwd_data  in  DATA_W  MEM-stage result (load data if load)
wb_rd  in  5  WB destination (= regfile WriteRegister)
wb_reg_write  in  1  = regfile RegWrite
wb_data  in  DATA_W  = regfile WriteData
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  ID/EX holds a real instruction
ex_op_a  out  DATA_W  resolved operand A
ex_op_b  out  DATA_W  resolved operand B, or imm
ex_store_data  out  DATA_W  resolved rm value (stores)
ex_rd  out  5  destination
ex_reg_write  out  1  gated by ex_valid
ex_is_load  out  1  gated by ex_valid
ex_ctrl  out  CTRL_W  control bundle
bubble_cnt  out  32  count of inserted stall bubbles (perf)

Behaviour:
- Reset (rst high at posedge): every ex_* output = 0 and bubble_cnt = 0. stall is combinational and reads 0 while the ID/EX register is empty.
- Per source s ∈ {rn, rm}, bypass priority (first match wins):
  1. s==ZR → 0.
  2. ex_valid & ex_reg_write & ex_rd==s → ex_result.
  3. mem_reg_write & mem_rd==s → mem_fwd_data.
  4. wb_reg_write & wb_rd==s → wb_data.
  5. Otherwise rf_rd1 / rf_rd2.
- A destination of ZR never matches.
- Load-use hazard: stall = id_valid & ex_valid & ex_is_load & ex_rd!=ZR & ((id_uses_rn & ex_rd==id_rn) | (id_uses_rm & ex_rd==id_rm)).
- On stall, at the posedge: the ID/EX register loads a bubble (all ex_* = 0) and bubble_cnt increments (saturates at all-ones). Upstream holds ID, so the next cycle re-evaluates with the load now in MEM and bypasses mem_fwd_data.
- flush high: the ID/EX register loads a bubble and bubble_cnt does not increment. flush beats stall. stall output is forced 0 when flush=1.
- id_valid=0: the register loads a bubble and bubble_cnt does not increment.
- Otherwise the register loads the resolved operands: ex_op_b = id_use_imm ? id_imm : fwd_rm; ex_store_data = fwd_rm. rd, flags and ctrl pass through.
- Latency: 1 cycle ID→EX; no stall when there is no hazard.
- rst has priority over flush and stall. rst mid-stall clears the bubble and leaves no residual stall.

Decomposition:
- Package cpu_pkg: DATA_W, ZR, the reg_idx_t (5-bit) typedef, and an idex_t struct for the pipeline register.
- One sub-module: fwd_mux (a single operand's priority bypass), instantiated twice.

Test Plan:
- Reset, then ID reads X5 with rf_rd1=0x11 and no hazards → next cycle ex_op_a=0x11, stall=0, bubble_cnt=0.
- WB writes X7=0xABC while ID reads rn=X7 and rf_rd1 is stale 0x0 → ex_op_a=0xABC.
- EX, MEM and WB all target X3, with ex_result=1, mem=2, wb=3 → ex_op_a=1. Drop the EX match → 2. Drop MEM → 3.
- EX holds a load to X9 and ID uses rm=X9 → stall=1 for 1 cycle, then a bubble (ex_valid=0), bubble_cnt=1. Next cycle mem_fwd_data=0x55 → ex_store_data=0x55.
- rn=X31 while EX writes X31 with ex_result=0xFF → ex_op_a=0, stall=0.
- flush and a load-use stall in the same cycle → stall=0, bubble inserted, bubble_cnt unchanged. Assert rst mid-stall → all ex_*=0 on the next cycle.
